csc_input_arbiter: RTL and testbench
====================================

# csc_input_arbiter

Round-robin burst arbiter that shares the single color space converter pixel input among NUM_SRC upstream pixel sources. Each source offers 8-bit R/G/B pixels on a valid/ready handshake. The arbiter grants one source at a time for a burst of up to BURST_LEN pixels and forwards accepted pixels, registered, onto the converter's data_valid_i/red_i/green_i/blue_i bus. The converter has no backpressure, so all flow control is applied on the source side.

## Interface
Parameters:
- NUM_SRC, 4: number of pixel sources (2..8).
- BURST_LEN, 16: maximum pixels accepted per grant (1..255).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_i  in  1  reset; asynchronous, active-high.
- src_valid  in  NUM_SRC  per-source pixel valid.
- src_ready  out  NUM_SRC  per-source ready; at most one bit high.
- src_red  in  NUM_SRC*8  packed red; source k uses bits [8k+7:8k].
- src_green  in  NUM_SRC*8  packed green.
- src_blue  in  NUM_SRC*8  packed blue.
- data_valid_i  out  1  pixel valid to converter.
- red_i  out  8  red to converter.
- green_i  out  8  green to converter.
- blue_i  out  8  blue to converter.
- grant_o  out  $clog2(NUM_SRC)  index of the currently or last granted source.
- busy_o  out  1  high while in BURST.

## Operation
- The FSM has two states, IDLE and BURST. It also holds a round-robin pointer rr_ptr, a grant register, and a burst counter cnt of width $clog2(BURST_LEN+1).
- IDLE:
  - src_ready is all zero.
  - If any src_valid is high, select the first requesting index at or after rr_ptr, searching upward modulo NUM_SRC. Register that index as the grant, clear cnt, and go to BURST.
  - If no src_valid is high, stay in IDLE.
- BURST:
  - src_ready[grant] is high and all other src_ready bits are low. src_ready is a combinational decode of state and grant.
  - Accept: src_valid[grant] && src_ready[grant]. On each accept, cnt increments.
  - If an accept occurs with cnt == BURST_LEN-1: go to IDLE and set rr_ptr = (grant+1) mod NUM_SRC.
  - If src_valid[grant] is low in a BURST cycle, the burst ends early: go to IDLE and set rr_ptr = (grant+1) mod NUM_SRC. No pixel is forwarded in that cycle.
  - src_valid changes on non-granted sources have no effect during BURST.
- Output register:
  - Every cycle, data_valid_i <= accept.
  - On accept, red_i/green_i/blue_i load the granted source's pixel. Otherwise they hold their previous value.
- Reset values: state = IDLE, rr_ptr = 0, grant_o = 0, cnt = 0, busy_o = 0, src_ready = 0, data_valid_i = 0, red_i/green_i/blue_i = 0.
- Reset asserted mid-burst: all of the above take effect immediately, asynchronously. The in-flight pixel is dropped. After reset releases, arbitration starts from source 0.

## Timing
- Latency: a pixel accepted in cycle N appears on the converter bus with data_valid_i high in cycle N+1.
- Arbitration costs one IDLE cycle. src_ready rises in the cycle after IDLE sees the request.
- Sustained throughput:
  - Single source: BURST_LEN pixels per BURST_LEN+1 cycles.
  - Contended sources: the same rate, with no extra idle cycles between grants.
- Burst end: src_ready drops in the cycle after the final accept.
- data_valid_i is never high for two pixels from different sources without an intervening low cycle.
- The source must hold src_valid and pixel data stable until accepted (AXI-style). The arbiter does not check this.

## Configuration
- Macro: CSC_ARB_PRIO_EN.
- Defined: source 0 has fixed priority. In IDLE, a high src_valid[0] wins regardless of rr_ptr. The remaining sources use round-robin among themselves. Bursts already in progress are never preempted.
- Not defined: pure round-robin as described in Operation.

## Test plan
- Reset mid-burst:
  - Stimulus: source 1 streaming (pixel 0x11/0x22/0x33 in flight), then assert rst_i asynchronously.
  - Required: data_valid_i, src_ready, busy_o and grant_o go to 0 at once. After release, source 0 is granted first.
- Single source, sustained:
  - Stimulus: src_valid[2] held high with incrementing pixels, BURST_LEN = 4.
  - Required: 4 consecutive data_valid_i pulses, 1 low cycle, repeating. Pixels appear in order, one cycle after accept.
- Round-robin rotation:
  - Stimulus: all 4 sources held valid.
  - Required: grant_o sequence 0, 1, 2, 3, 0, … Each grant lasts exactly BURST_LEN accepts.
- Early termination:
  - Stimulus: source 3 drops src_valid after 2 of 16 pixels while source 0 is waiting.
  - Required: busy_o falls. Source 0 is granted next (wrap from rr_ptr = 0), after exactly one IDLE cycle.
- Priority (CSC_ARB_PRIO_EN defined):
  - Stimulus: sources 0 and 2 both valid, rr_ptr = 1.
  - Required: source 0 granted first, source 2 second. Without the macro the order is 2 then 0.

Source files
------------

// File: rtl/csc_input_arbiter.sv
// Round-robin burst arbiter feeding the colour space converter pixel input.
// Build option CSC_ARB_PRIO_EN gives source 0 fixed priority at arbitration time.
module csc_input_arbiter #(
    parameter  int NUM_SRC   = 4,
    parameter  int BURST_LEN = 16,
    localparam int GW        = $clog2(NUM_SRC),
    localparam int CW        = $clog2(BURST_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [NUM_SRC-1:0]   src_valid,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic [NUM_SRC*8-1:0] src_red,
    input  logic [NUM_SRC*8-1:0] src_green,
    input  logic [NUM_SRC*8-1:0] src_blue,
    output logic                 data_valid_i,
    output logic [7:0]           red_i,
    output logic [7:0]           green_i,
    output logic [7:0]           blue_i,
    output logic [GW-1:0]        grant_o,
    output logic                 busy_o
);

    // state   | meaning
    // S_IDLE  | no grant; arbitrating among requesters (costs one cycle)
    // S_BURST | grant held; accepting up to BURST_LEN pixels from one source
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] grant;
    logic [CW-1:0] cnt;
    logic [GW-1:0] next_grant;
    logic [GW-1:0] cand;
    logic          found;
    logic          accept;
    logic          last;
    logic [7:0]    sel_red;
    logic [7:0]    sel_green;
    logic [7:0]    sel_blue;

    function automatic logic [GW-1:0] inc_mod(input logic [GW-1:0] v);
        return (v == GW'(NUM_SRC - 1)) ? '0 : v + GW'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        found      = 1'b0;
        next_grant = rr_ptr;
        cand       = rr_ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && src_valid[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
            cand = inc_mod(cand);
        end
`ifdef CSC_ARB_PRIO_EN
        if (src_valid[0]) begin
            found      = 1'b1;
            next_grant = '0;
        end
`endif
    end

    always_comb begin
        sel_red   = '0;
        sel_green = '0;
        sel_blue  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant == GW'(k)) begin
                sel_red   = src_red[k*8 +: 8];
                sel_green = src_green[k*8 +: 8];
                sel_blue  = src_blue[k*8 +: 8];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (state == S_BURST) begin
            src_ready[grant] = 1'b1;
        end
    end

    assign accept  = (state == S_BURST) && src_valid[grant];
    assign last    = (cnt == CW'(BURST_LEN - 1));
    assign busy_o  = (state == S_BURST);
    assign grant_o = grant;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            cnt          <= '0;
            data_valid_i <= 1'b0;
            red_i        <= '0;
            green_i      <= '0;
            blue_i       <= '0;
        end else begin
            data_valid_i <= accept;
            if (accept) begin
                red_i   <= sel_red;
                green_i <= sel_green;
                blue_i  <= sel_blue;
            end
            if (state == S_IDLE) begin
                if (found) begin
                    grant <= next_grant;
                    cnt   <= '0;
                    state <= S_BURST;
                end
            end else begin
                if (accept) begin
                    cnt <= cnt + CW'(1);
                end
                // A source going quiet ends its burst so others are not starved.
                if (!src_valid[grant] || last) begin
                    state  <= S_IDLE;
                    rr_ptr <= inc_mod(grant);
                end
            end
        end
    end

endmodule

// File: tb/tb_csc_input_arbiter.sv
// Bench for csc_input_arbiter: behavioural sources plus a queue scoreboard
// checked by an independent monitor on the converter bus.
module tb_csc_input_arbiter;
    localparam int NS = 4;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [NS-1:0]   src_valid;
    logic [NS-1:0]   src_ready;
    logic [NS*8-1:0] src_red;
    logic [NS*8-1:0] src_green;
    logic [NS*8-1:0] src_blue;
    logic            data_valid_i;
    logic [7:0]      red_i;
    logic [7:0]      green_i;
    logic [7:0]      blue_i;
    logic [1:0]      grant_o;
    logic            busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit en [NS];
    int rem[NS];
    int seq[NS];
    logic [NS-1:0] acc;

    int          exp_src[$];
    logic [23:0] exp_pix[$];

    csc_input_arbiter #(.NUM_SRC(NS), .BURST_LEN(BL)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_red     (src_red),
        .src_green   (src_green),
        .src_blue    (src_blue),
        .data_valid_i(data_valid_i),
        .red_i       (red_i),
        .green_i     (green_i),
        .blue_i      (blue_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Pixel seq s of source k: red = k*16+s, green = 2*red, blue = 3*red.
    function automatic logic [23:0] pix(input int k, input int s);
        logic [7:0] r;
        r = 8'(k * 16 + s);
        return {r, 8'(r * 2), 8'(r * 3)};
    endfunction

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            src_valid[k] = en[k] && (rem[k] > 0);
            {src_red[k*8 +: 8], src_green[k*8 +: 8], src_blue[k*8 +: 8]} = pix(k, seq[k]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int s);
        exp_src.push_back(k);
        exp_pix.push_back(pix(k, s));
    endtask

    task automatic src_go(input int k, input int s, input int n);
        seq[k] = s;
        rem[k] = n;
        en[k]  = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_src.size() != 0; i++) @(posedge clk);
        chk(name, exp_src.size(), 0);
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < NS; k++) en[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        for (int k = 0; k < NS; k++) begin
            en[k] = 1'b0; rem[k] = 0; seq[k] = 0;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_i = 1'b0;
    endtask

    // Source side: a handshake seen before the edge advances that source.
    initial begin
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (acc[k]) begin
                    seq[k]++;
                    rem[k]--;
                end
            end
        end
    end

    // Monitor: every converter beat must match the head of the scoreboard.
    logic       prev_dv = 1'b0;
    logic [1:0] prev_g  = '0;
    int         m_src;
    logic [23:0] m_pix;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && data_valid_i) begin
                if (prev_dv) chk("no_src_switch_without_gap", grant_o, prev_g);
                if (exp_src.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got pixel %0h with nothing expected",
                             {red_i, green_i, blue_i});
                end else begin
                    m_src = exp_src.pop_front();
                    m_pix = exp_pix.pop_front();
                    chk("beat_pixel", {red_i, green_i, blue_i}, m_pix);
                    chk("beat_grant", grant_o, m_src);
                end
            end
            prev_dv = data_valid_i && !rst_i;
            prev_g  = grant_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    bit          found;
    logic [13:0] got;
    logic [6:0]  bp;
    logic [1:0]  g_at;

    initial begin
        for (int k = 0; k < NS; k++) begin
            en[k] = 1'b0; rem[k] = 0; seq[k] = 0;
        end
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data_valid", data_valid_i, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_rgb", {red_i, green_i, blue_i}, 0);
        rst_i = 1'b0;
        @(posedge clk);
        #2;

        // Reset mid-burst while source 1's 0x11/0x22/0x33 is on the bus.
        push(1, 0);
        src_go(1, 0, 3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (data_valid_i && red_i == 8'h11) begin
                found = 1'b1;
                break;
            end
        end
        chk("t1_inflight_seen", found, 1);
        rst_i = 1'b1;
        #1;
        chk("t1_async_data_valid", data_valid_i, 0);
        chk("t1_async_src_ready", src_ready, 0);
        chk("t1_async_busy", busy_o, 0);
        chk("t1_async_grant", grant_o, 0);
        chk("t1_async_rgb", {red_i, green_i, blue_i}, 0);
        src_go(0, 0, 1);
        src_go(1, 2, 1);
        push(0, 0);
        push(1, 2);
        repeat (2) @(posedge clk);
        #2;
        rst_i = 1'b0;
        drain("t1_drain");

        // Single source sustained: 4 beats, 1 gap, repeating.
        do_reset();
        src_go(2, 0, 10);
        for (int s = 0; s < 10; s++) push(2, s);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_valid_i) begin
                found = 1'b1;
                break;
            end
        end
        chk("t2_first_beat", found, 1);
        got = '0;
        got[13] = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            @(negedge clk);
            got[i] = data_valid_i;
        end
        chk("t2_dv_pattern", got, 14'b11110111101100);
        drain("t2_drain");

        // Round robin over all four sources, wrapping back to 0.
        do_reset();
        src_go(0, 0, 8);
        src_go(1, 0, 4);
        src_go(2, 0, 4);
        src_go(3, 0, 4);
        for (int k = 0; k < NS; k++)
            for (int s = 0; s < BL; s++) push(k, s);
        for (int s = 4; s < 8; s++) push(0, s);
        drain("t3_drain");

        // Early termination by source 3 with source 0 waiting.
        do_reset();
        src_go(3, 0, 2);
        push(3, 0);
        push(3, 1);
        push(0, 0);
        @(posedge clk);
        #2;
        chk("t4_busy_on_grant", busy_o, 1);
        chk("t4_grant3", grant_o, 3);
        src_go(0, 0, 1);
        g_at = '1;
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            bp[i] = busy_o;
            if (i == 2) g_at = grant_o;
        end
        chk("t4_busy_pattern", bp, 7'b1110110);
        chk("t4_next_grant0", g_at, 0);
        drain("t4_drain");

        // Priority vs round robin with rr_ptr parked at 1.
        do_reset();
        src_go(0, 0, 1);
        push(0, 0);
        drain("t5_prime_drain");
        src_go(0, 1, 1);
        src_go(2, 0, 1);
`ifdef CSC_ARB_PRIO_EN
        push(0, 1);
        push(2, 0);
`else
        push(2, 0);
        push(0, 1);
`endif
        drain("t5_drain");

        chk("final_queue_empty", exp_src.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
